// File: rtl/pc_gen_multi.sv
// pc_gen_multi: fetch-block PC generator with per-slot mask; optional return-address stack under LEN5_PCGEN_RAS_EN.
// Latency: next PC registered (1 cycle); backpressure: pc_o held while valid_o && !ready_i, redirects still apply.
module pc_gen_multi #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter int              FETCH_W   = 2,
  parameter logic [XLEN-1:0] BOOT_PC   = '0,
  parameter int              RAS_DEPTH = 4,
  localparam int             SLOT_W    = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               except_i,
  input  logic [XLEN-1:0]    except_pc_i,
  input  logic               res_valid_i,
  input  logic               res_mispredict_i,
  input  logic               res_taken_i,
  input  logic [XLEN-1:0]    res_pc_i,
  input  logic [XLEN-1:0]    res_target_i,
  input  logic               pred_taken_i,
  input  logic [SLOT_W-1:0]  pred_slot_i,
  input  logic [XLEN-1:0]    pred_target_i,
  input  logic               pred_call_i,
  input  logic               pred_ret_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [FETCH_W-1:0] slot_mask_o
);

  localparam int IB     = ILEN / 8;
  localparam int BYTE_W = $clog2(IB);
  localparam int OFF_W  = $clog2(FETCH_W);
  localparam int BLK    = FETCH_W * IB;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   base;
  logic [SLOT_W-1:0] off;
  logic              fire;
  logic              mispr;
  logic              pred_vld;
  logic [XLEN-1:0]   pred_tgt;

  if (FETCH_W > 1) begin : g_off
    assign off = pc_q[OFF_W+BYTE_W-1:BYTE_W];
  end else begin : g_off_single
    assign off = '0;
  end

  assign base     = pc_q & ~XLEN'(BLK - 1);
  assign fire     = valid_o && ready_i;
  assign mispr    = res_valid_i && res_mispredict_i;
  // Predictions pointing before the entry slot belong to an already-skipped instruction
  assign pred_vld = pred_taken_i && (pred_slot_i >= off);

`ifdef LEN5_PCGEN_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] ras_cnt_q;
  logic             ras_upd, do_pop, do_push;
  logic [XLEN-1:0]  ret_addr;

  assign ptr_inc  = (ras_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + PTR_W'(1);
  assign ptr_dec  = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - PTR_W'(1);
  assign ras_upd  = fire && pred_vld && !except_i && !mispr;
  assign do_pop   = ras_upd && pred_ret_i && (ras_cnt_q != '0);
  assign do_push  = ras_upd && pred_call_i;
  assign ret_addr = base + (XLEN'(pred_slot_i) + XLEN'(1)) * XLEN'(IB);
  assign pred_tgt = (pred_ret_i && ras_cnt_q != '0) ? ras_q[ptr_dec] : pred_target_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (do_pop && !do_push) begin
      ras_ptr_q <= ptr_dec;
      ras_cnt_q <= ras_cnt_q - CNT_W'(1);
    end else if (do_push && !do_pop) begin
      ras_ptr_q <= ptr_inc;
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
    end
  end

  // Pop+push replaces the top in place; a full stack overwrites its oldest slot
  always_ff @(posedge clk_i) begin
    if (do_push && do_pop) ras_q[ptr_dec] <= ret_addr;
    else if (do_push)      ras_q[ras_ptr_q] <= ret_addr;
  end
`else
  logic unused_ras;
  assign unused_ras = pred_call_i ^ pred_ret_i ^ (RAS_DEPTH > 0);
  assign pred_tgt   = pred_target_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = RUN;
  end

  always_comb begin
    valid_o = (state_q == RUN);
  end

  always_comb begin
    pc_d = pc_q;
    if (except_i)             pc_d = except_pc_i;
    else if (mispr)           pc_d = res_taken_i ? res_target_i : res_pc_i + XLEN'(IB);
    else if (fire && pred_vld) pc_d = pred_tgt;
    else if (fire)            pc_d = base + XLEN'(BLK);
  end

  assign pc_o = pc_q;

  always_comb begin
    slot_mask_o = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_mask_o[i] = valid_o && (SLOT_W'(i) >= off) && (!pred_vld || SLOT_W'(i) <= pred_slot_i);
    end
  end

endmodule

// File: doc/pc_gen_multi.md
Name: pc_gen_multi

Overview:
- Parametrised next-generation PC generator for the frontend.
- Produces fetch-block PCs for a FETCH_W-wide fetch stage under a valid/ready handshake, with a per-slot valid mask.
- Redirects (exception, then misprediction) are captured even while fetch is stalled and are never lost.
- Branch-prediction redirects apply on handshake; an optional return-address stack is available.

Parameters:
XLEN, 64, address width
ILEN, 32, instruction width in bits; instruction size = ILEN/8 bytes
FETCH_W, 2, instructions per fetch block; power of 2, at least 1
BOOT_PC, 64'h0, PC presented after reset
RAS_DEPTH, 4, return-address-stack entries; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
except_i  in  1  exception redirect request
except_pc_i  in  XLEN  exception target
res_valid_i  in  1  branch resolution valid
res_mispredict_i  in  1  resolved branch was mispredicted
res_taken_i  in  1  resolved branch taken
res_pc_i  in  XLEN  PC of resolved branch
res_target_i  in  XLEN  resolved taken target
pred_taken_i  in  1  predictor says a branch in the current block is taken
pred_slot_i  in  $clog2(FETCH_W) (min 1)  slot index of the predicted-taken instruction
pred_target_i  in  XLEN  predicted target
pred_call_i  in  1  predicted-taken instruction is a call (RAS only)
pred_ret_i  in  1  predicted-taken instruction is a return (RAS only)
ready_i  in  1  fetch accepts the current block
valid_o  out  1  pc_o / slot_mask_o are valid
pc_o  out  XLEN  PC of the first valid instruction in the block
slot_mask_o  out  FETCH_W  per-slot valid bits

Behaviour:
- Definitions:
  - OFF = pc_o bits [$clog2(FETCH_W)+$clog2(ILEN/8)-1 : $clog2(ILEN/8)].
  - BASE = pc_o with those bits and the byte-offset bits cleared.
  - BLK = FETCH_W*ILEN/8.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- Reset (rst_i=1 sampled at a clock edge):
  - pc_o=BOOT_PC, valid_o=0, slot_mask_o=0, FSM=BOOT.
  - RAS pointer and count are cleared.
  - Reset mid-operation discards any pending redirect.
- FSM:
  - BOOT: valid_o=0. Unconditionally goes to RUN on the next edge.
  - RUN: valid_o=1. Stays in RUN.
  - Reset returns the FSM to BOOT from any state.
- Handshake:
  - Fire = valid_o && ready_i.
  - pc_o is stable while valid_o && !ready_i, unless a redirect occurs.
- Next-PC priority, evaluated every RUN cycle and registered, so there is 1-cycle latency:
  1. except_i -> except_pc_i. Applied regardless of ready_i; the current block is dropped.
  2. res_valid_i && res_mispredict_i -> res_target_i if res_taken_i, else res_pc_i+ILEN/8. Applied regardless of ready_i.
  3. Fire with a valid prediction -> pred_target_i. A prediction is valid when pred_taken_i && pred_slot_i >= OFF.
  4. Fire without a valid prediction -> BASE+BLK.
  5. Otherwise hold.
- Redirects in BOOT are registered into pc_o; the FSM still moves to RUN.
- A prediction with pred_slot_i < OFF is ignored and treated as not-taken.
- slot_mask_o (combinational from the registered pc_o and the pred inputs):
  - Bit i is set iff valid_o && i>=OFF && (no valid prediction || i<=pred_slot_i).
- Misaligned byte-offset bits of redirect targets are carried into pc_o unmodified. Alignment checking is not this block's job.

Optional Feature:
- Macro LEN5_PCGEN_RAS_EN.
- Defined: RAS_DEPTH-entry circular return-address stack.
  - Fire with a valid prediction && pred_call_i: push BASE+(pred_slot_i+1)*ILEN/8. When full, the oldest entry is overwritten.
  - Fire with a valid prediction && pred_ret_i && count>0: the next PC is the RAS top instead of pred_target_i, and the entry is popped.
  - Fire with a valid prediction && pred_ret_i && count==0: pred_target_i is used.
  - pred_call_i && pred_ret_i together: pop first, then push. The next PC is the old top.
  - RAS is not updated on exception or mispredict cycles; redirect priority suppresses the update.
- Undefined: pred_call_i and pred_ret_i are present but ignored, no RAS storage exists, and RAS_DEPTH is unused.

Test Plan:
- Config for all tests: FETCH_W=2, XLEN=64, BOOT_PC=0x80000000.
- Reset: hold rst_i 3 cycles -> pc_o=0x80000000, valid_o=0, mask=00. First cycle after release valid_o=0; second cycle valid_o=1, mask=11.
- Stall then sequential: ready_i=0 for 3 cycles -> pc_o holds 0x80000000. ready_i=1 -> next pc_o=0x80000008, then 0x80000010.
- Mispredict not-taken during stall: ready_i=0, res_pc=0x80000100 -> next pc_o=0x80000104, mask=10. On fire -> 0x80000108, mask=11.
- Simultaneous redirects: except_i with except_pc=0x200, plus mispredict-taken with target 0x300, same cycle -> pc_o=0x200. Also pc_o=0xFFFFFFFFFFFFFFF8 with fire -> pc_o=0x0 (wrap).
- Prediction: pc_o=0x80000000, pred slot 0, target 0x80000040 -> mask=01, next 0x80000040. pc_o=0x80000004 with pred slot 0 -> ignored, mask=10, next 0x80000008.
- RAS (macro on, RAS_DEPTH=4):
  - Call predicted at slot 1 of block 0x1000 -> pushes 0x1008.
  - Later return with pred_target=0xDEAD -> next pc_o=0x1008.
  - Five calls, then five returns -> the fifth return uses pred_target_i.
